// File: rtl/rv32i_fetch_unit_if.sv
// rtl/rv32i_fetch_unit_if.sv - fetch unit bus bundle: imem request/response, redirect, decode handshake
// Signals:
//   o_imem_req/o_imem_addr      fetch request and word address (fetch unit drives)
//   i_imem_gnt                  request accepted this cycle
//   i_imem_rvalid/i_imem_rdata  in-order read response
//   i_redirect/i_redirect_pc    branch/jump target from execute
//   i_stall                     decode holds the current instruction
//   o_valid/o_inst/o_pc         instruction and its address to decode
//   o_misaligned                sticky misaligned-target flag
// Modports: master = fetch unit side, slave = memory/pipeline side.
interface rv32i_fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_misaligned;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_inst, o_pc, o_misaligned,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_stall
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_inst, o_pc, o_misaligned,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_stall
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// rtl/rv32i_fetch_unit.sv - RV32I instruction fetch unit with in-order imem interface and instruction buffer
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset
//   bus    rv32i_fetch_unit_if.master (imem request/response, redirect, stall, decode outputs)
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  instruction buffer entries (power of 2, >= 2)
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   - a redirect to a non-word-aligned target halts fetch and sets sticky o_misaligned
//   undefined - redirect target low bits are forced to zero, o_misaligned is tied low
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic                i_clk,
  input logic                i_rst,
  rv32i_fetch_unit_if.master bus
);

  localparam int PW  = $clog2(BUF_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW:0]   DEPTH_C1 = CW1'(BUF_DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   pc_mem   [BUF_DEPTH];
  logic [31:0]   inst_mem [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard_cnt;
  logic [CW-1:0] out_nxt, discard_nxt;
  logic [31:0]   fetch_pc, resp_pc;
  logic          misaligned;

  logic          req, grant, rsp, push, pop, valid;
  logic          redirect_act, redirect_bad;
  logic [31:0]   redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_pc  = bus.i_redirect_pc;
  assign redirect_bad = (bus.i_redirect_pc[1:0] != 2'b00);
`else
  assign redirect_pc  = {bus.i_redirect_pc[31:2], 2'b00};
  assign redirect_bad = 1'b0;
`endif

  assign valid = !i_rst && (count != '0);

  always_comb begin
    state_nxt    = state;
    discard_nxt  = discard_cnt;
    req          = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    redirect_act = 1'b0;

    // Occupancy is judged at cycle start; a pop this cycle does not open a slot,
    // so a granted response always has a free entry when it returns.
    if (!i_rst && state == FETCH)
      req = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C1;

    grant = req && bus.i_imem_gnt;
    rsp   = bus.i_imem_rvalid && (outstanding != '0);
    // Outstanding after this cycle's grant and response; also the stale count on redirect.
    out_nxt = outstanding + CW'(grant) - CW'(rsp);

    redirect_act = bus.i_redirect && (state != HALT);

    case (state)
      FETCH, DRAIN: begin
        if (redirect_act) begin
          discard_nxt = out_nxt;
          if (redirect_bad)
            state_nxt = HALT;
          else if (out_nxt != '0)
            state_nxt = DRAIN;
          else
            state_nxt = FETCH;
        end else if (state == DRAIN) begin
          if (rsp && discard_cnt != '0) begin
            discard_nxt = discard_cnt - CW'(1);
            if (discard_cnt == CW'(1))
              state_nxt = FETCH;
          end
        end else begin
          push = bus.i_imem_rvalid;
          pop  = valid && !bus.i_stall;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      misaligned  <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      discard_cnt <= discard_nxt;
      if (redirect_act) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        if (redirect_bad)
          misaligned <= 1'b1;
      end else begin
        if (grant)
          fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          pc_mem[wr_ptr]   <= resp_pc;
          inst_mem[wr_ptr] <= bus.i_imem_rdata;
          wr_ptr           <= wr_ptr + PW'(1);
          resp_pc          <= resp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  assign bus.o_imem_req   = req;
  assign bus.o_imem_addr  = fetch_pc;
  assign bus.o_valid      = valid;
  assign bus.o_inst       = valid ? inst_mem[rd_ptr] : 32'd0;
  assign bus.o_pc         = valid ? pc_mem[rd_ptr] : 32'd0;
  assign bus.o_misaligned = misaligned && !i_rst;

  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(bus.i_imem_rvalid && outstanding == '0))
        else $error("imem rvalid with no outstanding request");
      assert (!(push && !pop && count == DEPTH_C))
        else $error("instruction buffer overflow");
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb/tb_rv32i_fetch_unit.sv - directed and randomized self-checking bench for rv32i_fetch_unit
module tb_rv32i_fetch_unit;

  logic clk;
  logic rst;

  rv32i_fetch_unit_if bus ();

  rv32i_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Memory responder: rdata equals address, in-order, latency in [lat_min, lat_max].
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] grant_log[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          gnt_rand = 1'b0;

  initial begin
    int d;
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = 32'd0;
      if (rst) begin
        rq.delete();
        grant_log.delete();
        bus.i_imem_gnt = 1'b0;
        last_due = 0;
      end else begin
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          bus.i_imem_rvalid = 1'b1;
          bus.i_imem_rdata  = rq[0].addr;
          void'(rq.pop_front());
        end
        bus.i_imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.o_imem_req && bus.i_imem_gnt) begin
          d = cyc + $urandom_range(lat_min, lat_max);
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          rq.push_back('{addr: bus.o_imem_addr, due: d});
          grant_log.push_back(bus.o_imem_addr);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'd0;
    bus.i_stall       = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Advance until o_valid is seen (current cycle included), bounded.
  task automatic next_valid(input string tag, output logic [31:0] pc, output logic [31:0] inst);
    bit found = 1'b0;
    pc   = 32'hdead_beef;
    inst = 32'hdead_beef;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_valid) begin
        found = 1'b1;
        pc    = bus.o_pc;
        inst  = bus.o_inst;
        break;
      end
      step();
    end
    chk({tag, "_found"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [31:0] pc, inst, exp_pc, tgt;
    bit          redir;

    rst               = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'd0;
    bus.i_stall       = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_req",        {31'd0, bus.o_imem_req},   32'd0);
    chk("rst_valid",      {31'd0, bus.o_valid},      32'd0);
    chk("rst_misaligned", {31'd0, bus.o_misaligned}, 32'd0);
    chk("rst_inst",       bus.o_inst,                32'd0);
    chk("rst_pc",         bus.o_pc,                  32'd0);
    chk("rst_addr",       bus.o_imem_addr,           32'd0);

    // Cold start, 1-cycle memory
    rst = 1'b0;
    step();
    chk("cold_req1",  {31'd0, bus.o_imem_req}, 32'd1);
    chk("cold_addr1", bus.o_imem_addr,         32'h0);
    step();
    chk("cold_req2",  {31'd0, bus.o_imem_req}, 32'd1);
    chk("cold_addr2", bus.o_imem_addr,         32'h4);
    step();
    chk("cold_valid3", {31'd0, bus.o_valid}, 32'd1);
    chk("cold_pc0",    bus.o_pc,             32'h0);
    chk("cold_inst0",  bus.o_inst,           32'h0);
    step();
    next_valid("cold_v1", pc, inst);
    chk("cold_pc1",   pc,   32'h4);
    chk("cold_inst1", inst, 32'h4);
    step();
    next_valid("cold_v2", pc, inst);
    chk("cold_pc2",   pc,   32'h8);
    chk("cold_inst2", inst, 32'h8);
    chk("cold_grants", grant_log.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
    if (grant_log.size() >= 3) begin
      chk("cold_gaddr0", grant_log[0], 32'h0);
      chk("cold_gaddr1", grant_log[1], 32'h4);
      chk("cold_gaddr2", grant_log[2], 32'h8);
    end

    // Stall with full buffer
    do_reset();
    step();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.o_valid && bus.o_pc == 32'h4) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      chk("stall_reach4", {31'd0, seen}, 32'd1);
    end
    bus.i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("stall_pc",    bus.o_pc,             32'h4);
      if (i >= 2) chk("stall_noreq", {31'd0, bus.o_imem_req}, 32'd0);
      step();
    end
    bus.i_stall = 1'b0;
    chk("stall_drop_pc", bus.o_pc, 32'h4);
    step();
    chk("stall_resume_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("stall_resume_pc",    bus.o_pc,             32'h8);

    // Redirect with 2 outstanding on 3-cycle memory
    lat_min = 3;
    lat_max = 3;
    do_reset();
    step();
    step();
    step();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h100;
    step();
    bus.i_redirect = 1'b0;
    chk("redir_c4_valid",  {31'd0, bus.o_valid},       32'd0);
    chk("redir_c4_req",    {31'd0, bus.o_imem_req},    32'd0);
    chk("redir_c4_rvalid", {31'd0, bus.i_imem_rvalid}, 32'd1);
    step();
    chk("redir_c5_req",    {31'd0, bus.o_imem_req},    32'd0);
    chk("redir_c5_rvalid", {31'd0, bus.i_imem_rvalid}, 32'd1);
    step();
    chk("redir_c6_req",  {31'd0, bus.o_imem_req}, 32'd1);
    chk("redir_c6_addr", bus.o_imem_addr,         32'h100);
    next_valid("redir_v", pc, inst);
    chk("redir_pc",   pc,   32'h100);
    chk("redir_inst", inst, 32'h100);

    // Redirect colliding with rvalid and stall, 1-cycle memory
    lat_min = 1;
    lat_max = 1;
    do_reset();
    step();
    step();
    step();
    chk("coll_pre_valid",  {31'd0, bus.o_valid},       32'd1);
    chk("coll_pre_rvalid", {31'd0, bus.i_imem_rvalid}, 32'd1);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h40;
    bus.i_stall       = 1'b1;
    step();
    bus.i_redirect = 1'b0;
    bus.i_stall    = 1'b0;
    chk("coll_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("coll_addr",  bus.o_imem_addr,      32'h40);
    next_valid("coll_v1", pc, inst);
    chk("coll_pc1", pc, 32'h40);
    step();
    next_valid("coll_v2", pc, inst);
    chk("coll_pc2", pc, 32'h44);

    // Misaligned redirect
    do_reset();
    step();
    step();
    step();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h102;
    step();
    bus.i_redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      chk("mis_flag",  {31'd0, bus.o_misaligned}, 32'd1);
      chk("mis_noreq", {31'd0, bus.o_imem_req},   32'd0);
      chk("mis_valid", {31'd0, bus.o_valid},      32'd0);
      step();
    end
`else
    chk("mis_flag", {31'd0, bus.o_misaligned}, 32'd0);
    chk("mis_addr", bus.o_imem_addr,           32'h100);
    next_valid("mis_v", pc, inst);
    chk("mis_pc", pc, 32'h100);
`endif

    // Random grant, latency, stall and redirects against a PC model
    gnt_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 4;
    do_reset();
    exp_pc = 32'h0;
    for (int i = 0; i < 10000; i++) begin
      bus.i_stall = ($urandom_range(0, 3) == 0);
      redir       = ($urandom_range(0, 29) == 0);
      tgt         = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      bus.i_redirect    = redir;
      bus.i_redirect_pc = tgt;
      if (redir) begin
        exp_pc = tgt;
      end else if (bus.o_valid && !bus.i_stall) begin
        chk("rand_pc",   bus.o_pc,   exp_pc);
        chk("rand_inst", bus.o_inst, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      step();
    end
    bus.i_redirect = 1'b0;
    bus.i_stall    = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
